// File: rtl/imm_pkg.sv
// Shared definitions for the pipelined immediate generator.
// Opcodes, immediate format encoding and XLEN legality.
package imm_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [2:0] {
        FMT_NONE  = 3'd0,
        FMT_I     = 3'd1,
        FMT_SHAMT = 3'd2,
        FMT_S     = 3'd3,
        FMT_B     = 3'd4,
        FMT_U     = 3'd5,
        FMT_J     = 3'd6
    } imm_fmt_t;

    function automatic bit xlen_ok(input int xlen);
        return (xlen == 32) || (xlen == 64);
    endfunction

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate decode: instruction word to imm/fmt/illegal.
// Shift immediates use 5-bit shamt for RV32 and *W ops, 6-bit otherwise.
module imm_decode
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr_i,
    output logic [XLEN-1:0] imm_o,
    output imm_fmt_t        fmt_o,
    output logic            illegal_o
);

    logic [6:0] opc;
    logic [2:0] f3;
    logic       s;
    logic       is_shift;
    logic       sh5;

    assign opc = instr_i[6:0];
    assign f3  = instr_i[14:12];
    assign s   = instr_i[31];

    always_comb begin
        imm_o     = '0;
        fmt_o     = FMT_NONE;
        illegal_o = 1'b0;
        is_shift  = 1'b0;
        sh5       = (XLEN == 32);
        unique case (opc)
            OP_LOAD, OP_JALR: begin
                fmt_o = FMT_I;
                imm_o = {{(XLEN-12){s}}, instr_i[31:20]};
            end
            OP_IMM: begin
                if (f3 == 3'd1 || f3 == 3'd5) begin
                    is_shift = 1'b1;
                end else begin
                    fmt_o = FMT_I;
                    imm_o = {{(XLEN-12){s}}, instr_i[31:20]};
                end
            end
            OP_IMM32: begin
                if (XLEN == 64) begin
                    sh5 = 1'b1;
                    if (f3 == 3'd1 || f3 == 3'd5) begin
                        is_shift = 1'b1;
                    end else begin
                        fmt_o = FMT_I;
                        imm_o = {{(XLEN-12){s}}, instr_i[31:20]};
                    end
                end
            end
            OP_STORE: begin
                fmt_o = FMT_S;
                imm_o = {{(XLEN-12){s}}, instr_i[31:25], instr_i[11:7]};
            end
            OP_BRANCH: begin
                fmt_o = FMT_B;
                imm_o = {{(XLEN-13){s}}, s, instr_i[7],
                         instr_i[30:25], instr_i[11:8], 1'b0};
            end
            OP_JAL: begin
                fmt_o = FMT_J;
                imm_o = {{(XLEN-21){s}}, s, instr_i[19:12],
                         instr_i[20], instr_i[30:21], 1'b0};
            end
            OP_LUI, OP_AUIPC: begin
                fmt_o = FMT_U;
                imm_o = {{(XLEN-32){s}}, instr_i[31:12], 12'b0};
            end
            default: begin
                fmt_o = FMT_NONE;
            end
        endcase

        // Illegal shifts still produce their immediate.
        if (is_shift) begin
            fmt_o = FMT_SHAMT;
            if (sh5) begin
                imm_o     = {{(XLEN-5){1'b0}}, instr_i[24:20]};
                illegal_o = instr_i[25] ||
                            ((instr_i[31:25] != 7'b0000000) &&
                             (instr_i[31:25] != 7'b0100000));
            end else begin
                imm_o     = {{(XLEN-6){1'b0}}, instr_i[25:20]};
                illegal_o = (instr_i[31:26] != 6'b000000) &&
                            (instr_i[31:26] != 6'b010000);
            end
        end
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: decode on input, output reg + 1-entry skid.
// in_ready is the registered skid-empty flag, so no path from out_ready.
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_illegal
);

    if (!xlen_ok(XLEN)) begin : g_bad_xlen
        $error("imm_gen_pipe: XLEN must be 32 or 64");
    end

    logic [XLEN-1:0] dec_imm;
    imm_fmt_t        dec_fmt;
    logic            dec_ill;

    imm_decode #(.XLEN(XLEN)) u_dec (
        .instr_i   (in_instr),
        .imm_o     (dec_imm),
        .fmt_o     (dec_fmt),
        .illegal_o (dec_ill)
    );

    logic            ov_q,  ov_d;
    logic [31:0]     oi_q,  oi_d;
    logic [XLEN-1:0] oimm_q, oimm_d;
    imm_fmt_t        ofmt_q, ofmt_d;
    logic            oill_q, oill_d;

    logic            sv_q,  sv_d;
    logic [31:0]     si_q,  si_d;
    logic [XLEN-1:0] simm_q, simm_d;
    imm_fmt_t        sfmt_q, sfmt_d;
    logic            sill_q, sill_d;

    logic accept;
    logic out_free;

    assign in_ready = !sv_q;
    assign accept   = in_valid && !sv_q;
    assign out_free = !ov_q || out_ready;

    always_comb begin
        ov_d   = ov_q;
        oi_d   = oi_q;
        oimm_d = oimm_q;
        ofmt_d = ofmt_q;
        oill_d = oill_q;
        sv_d   = sv_q;
        si_d   = si_q;
        simm_d = simm_q;
        sfmt_d = sfmt_q;
        sill_d = sill_q;
        if (flush) begin
            ov_d = 1'b0;
            sv_d = 1'b0;
        end else if (out_free) begin
            if (sv_q) begin
                // Skid full implies no accept this cycle.
                ov_d   = 1'b1;
                oi_d   = si_q;
                oimm_d = simm_q;
                ofmt_d = sfmt_q;
                oill_d = sill_q;
                sv_d   = 1'b0;
            end else if (accept) begin
                ov_d   = 1'b1;
                oi_d   = in_instr;
                oimm_d = dec_imm;
                ofmt_d = dec_fmt;
                oill_d = dec_ill;
            end else begin
                ov_d = 1'b0;
            end
        end else if (accept) begin
            sv_d   = 1'b1;
            si_d   = in_instr;
            simm_d = dec_imm;
            sfmt_d = dec_fmt;
            sill_d = dec_ill;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ov_q   <= 1'b0;
            oi_q   <= '0;
            oimm_q <= '0;
            ofmt_q <= FMT_NONE;
            oill_q <= 1'b0;
            sv_q   <= 1'b0;
            si_q   <= '0;
            simm_q <= '0;
            sfmt_q <= FMT_NONE;
            sill_q <= 1'b0;
        end else begin
            ov_q   <= ov_d;
            oi_q   <= oi_d;
            oimm_q <= oimm_d;
            ofmt_q <= ofmt_d;
            oill_q <= oill_d;
            sv_q   <= sv_d;
            si_q   <= si_d;
            simm_q <= simm_d;
            sfmt_q <= sfmt_d;
            sill_q <= sill_d;
        end
    end

    assign out_valid   = ov_q;
    assign out_instr   = oi_q;
    assign out_imm     = oimm_q;
    assign out_fmt     = ofmt_q;
    assign out_illegal = oill_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe, XLEN=32 and XLEN=64 side by side.
module tb_imm_gen_pipe;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_instr;
    logic        out_ready;

    logic        rdy32, ov32, ill32;
    logic [31:0] oi32, imm32;
    logic [2:0]  fmt32;
    logic        rdy64, ov64, ill64;
    logic [31:0] oi64;
    logic [63:0] imm64;
    logic [2:0]  fmt64;

    int n_chk = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    imm_gen_pipe #(.XLEN(32)) u32 (
        .clock(clock), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy32), .in_instr(in_instr),
        .out_valid(ov32), .out_ready(out_ready), .out_instr(oi32),
        .out_imm(imm32), .out_fmt(fmt32), .out_illegal(ill32)
    );

    imm_gen_pipe #(.XLEN(64)) u64 (
        .clock(clock), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy64), .in_instr(in_instr),
        .out_valid(ov64), .out_ready(out_ready), .out_instr(oi64),
        .out_imm(imm64), .out_fmt(fmt64), .out_illegal(ill64)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic xfer(input logic [31:0] ins);
        in_valid = 1'b1;
        in_instr = ins;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic vec(input string tag, input logic [31:0] ins,
                       input logic [63:0] e32, input logic [2:0] f32,
                       input logic i32,
                       input logic [63:0] e64, input logic [2:0] f64,
                       input logic i64);
        xfer(ins);
        chk({tag, ".v32"}, 64'(ov32), 64'(1));
        chk({tag, ".instr"}, 64'(oi32), 64'(ins));
        chk({tag, ".imm32"}, 64'(imm32), e32);
        chk({tag, ".fmt32"}, 64'(fmt32), 64'(f32));
        chk({tag, ".ill32"}, 64'(ill32), 64'(i32));
        chk({tag, ".imm64"}, imm64, e64);
        chk({tag, ".fmt64"}, 64'(fmt64), 64'(f64));
        chk({tag, ".ill64"}, 64'(ill64), 64'(i64));
    endtask

    function automatic logic [31:0] addi(input int k);
        return (32'(k) << 20) | 32'h0000_0093;
    endfunction

    initial begin
        int tx;
        int rx;
        logic ir_at3;

        reset_n   = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = 32'h0;
        out_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        chk("rst.ov", 64'(ov32), 64'(0));
        chk("rst.ready", 64'(rdy32), 64'(1));
        chk("rst.imm64", imm64, 64'(0));
        chk("rst.fmt", 64'(fmt64), 64'(0));
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        // fmt: NONE0 I1 SHAMT2 S3 B4 U5 J6
        vec("addi", 32'hFFF00093, 64'hFFFFFFFF, 3'd1, 1'b0,
            64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0);
        vec("slli31", 32'h01F09093, 64'h1F, 3'd2, 1'b0,
            64'h1F, 3'd2, 1'b0);
        vec("slli_b25", 32'h02009093, 64'h0, 3'd2, 1'b1,
            64'h20, 3'd2, 1'b0);
        vec("slli63", 32'h03F09093, 64'h1F, 3'd2, 1'b1,
            64'h3F, 3'd2, 1'b0);
        vec("srai", 32'h4010D093, 64'h1, 3'd2, 1'b0,
            64'h1, 3'd2, 1'b0);
        vec("badf7", 32'h8010D093, 64'h1, 3'd2, 1'b1,
            64'h1, 3'd2, 1'b1);
        vec("sw", 32'hFE112E23, 64'hFFFFFFFC, 3'd3, 1'b0,
            64'hFFFFFFFFFFFFFFFC, 3'd3, 1'b0);
        vec("beq", 32'hFE000EE3, 64'hFFFFFFFC, 3'd4, 1'b0,
            64'hFFFFFFFFFFFFFFFC, 3'd4, 1'b0);
        vec("lui", 32'h800000B7, 64'h80000000, 3'd5, 1'b0,
            64'hFFFFFFFF80000000, 3'd5, 1'b0);
        vec("auipc", 32'h00001097, 64'h1000, 3'd5, 1'b0,
            64'h1000, 3'd5, 1'b0);
        vec("jal", 32'h0080006F, 64'h8, 3'd6, 1'b0,
            64'h8, 3'd6, 1'b0);
        vec("lw", 32'h00412083, 64'h4, 3'd1, 1'b0,
            64'h4, 3'd1, 1'b0);
        vec("jalr", 32'hFFC08067, 64'hFFFFFFFC, 3'd1, 1'b0,
            64'hFFFFFFFFFFFFFFFC, 3'd1, 1'b0);
        vec("add", 32'h00000033, 64'h0, 3'd0, 1'b0,
            64'h0, 3'd0, 1'b0);
        vec("slliw", 32'h01F0909B, 64'h0, 3'd0, 1'b0,
            64'h1F, 3'd2, 1'b0);
        vec("slliw_b25", 32'h0200909B, 64'h0, 3'd0, 1'b0,
            64'h0, 3'd2, 1'b1);
        vec("addiw", 32'hFFF0809B, 64'h0, 3'd0, 1'b0,
            64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0);
        @(posedge clock);
        #1;
        chk("idle.ov", 64'(ov32), 64'(0));

        // Stream of 6 with out_ready low in cycles 2..4.
        tx = 0;
        rx = 0;
        ir_at3 = 1'b1;
        for (int c = 0; c < 30; c++) begin
            out_ready = !(c >= 2 && c <= 4);
            in_valid  = (tx < 6);
            in_instr  = addi(tx + 1);
            @(negedge clock);
            if (c == 3) ir_at3 = rdy32;
            if (ov32 && out_ready) begin
                chk("stream.imm", 64'(imm32), 64'(rx + 1));
                rx++;
            end
            if (in_valid && rdy32) tx++;
            @(posedge clock);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("stream.ready_low", 64'(ir_at3), 64'(0));
        chk("stream.count", 64'(rx), 64'(6));

        // Fill to occupancy 2, then flush with an input offered.
        out_ready = 1'b0;
        xfer(addi(5));
        xfer(addi(6));
        chk("occ2.ready", 64'(rdy32), 64'(0));
        chk("occ2.ov", 64'(ov32), 64'(1));
        flush    = 1'b1;
        in_valid = 1'b1;
        in_instr = addi(7);
        @(posedge clock);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush.ov", 64'(ov32), 64'(0));
        chk("flush.ready", 64'(rdy32), 64'(1));
        out_ready = 1'b1;
        xfer(addi(9));
        chk("postflush.ov", 64'(ov32), 64'(1));
        chk("postflush.imm", 64'(imm32), 64'(9));
        @(posedge clock);
        #1;
        chk("postflush.alone", 64'(ov32), 64'(0));

        // Asynchronous reset mid-stall.
        out_ready = 1'b0;
        xfer(32'hFE112E23);
        xfer(32'h800000B7);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst.ov", 64'(ov64), 64'(0));
        chk("arst.ready", 64'(rdy64), 64'(1));
        chk("arst.imm", imm64, 64'(0));
        chk("arst.fmt", 64'(fmt64), 64'(0));
        chk("arst.ill", 64'(ill64), 64'(0));
        chk("arst.instr", 64'(oi64), 64'(0));
        @(posedge clock);
        #1;
        reset_n   = 1'b1;
        out_ready = 1'b1;
        xfer(32'h0080006F);
        chk("after_rst.imm", imm64, 64'h8);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule
